// File: rtl/smalldiv_digitizer.sv
// smalldiv_digitizer: turns a binary value into base-RADIX digits, LSB first,
// one digit per cycle on a valid/ready stream. Each step divides the work
// register by the constant RADIX in a single combinational stage.
module smalldiv_digitizer #(
    parameter int RADIX        = 10,
    parameter int RADIX_WIDTH  = $clog2(RADIX),
    parameter int VALUE_WIDTH  = 18,
    parameter int NUM_DIGITS   = 6,
    parameter bit FIXED_LENGTH = 1'b0
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [VALUE_WIDTH-1:0]           in_value,
    output logic                             digit_valid,
    input  logic                             digit_ready,
    output logic [RADIX_WIDTH-1:0]           digit,
    output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_index,
    output logic                             digit_last
);

    localparam int IDX_W = $clog2(NUM_DIGITS + 1);

    // True when NUM_DIGITS base-RADIX digits can represent every input value.
    function automatic bit digits_cover_range();
        longint limit;
        longint p;
        limit = (longint'(1) << VALUE_WIDTH) - 1;
        p     = 1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (p <= limit) p = p * RADIX;
        end
        return p > limit;
    endfunction

    if (RADIX < 2) begin : g_bad_radix
        $error("smalldiv_digitizer: RADIX must be >= 2");
    end
    if (!digits_cover_range()) begin : g_bad_digits
        $error("smalldiv_digitizer: RADIX^NUM_DIGITS does not cover 2^VALUE_WIDTH-1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [VALUE_WIDTH-1:0]  work_q,  work_d;
    logic [IDX_W-1:0]        index_q, index_d;

    // Constant-divide stage; quotient kept at full width so no bits are lost.
    logic [VALUE_WIDTH-1:0]  quot;
    logic [RADIX_WIDTH-1:0]  rem;
    logic                    is_last;

    assign quot = work_q / VALUE_WIDTH'(RADIX);
    assign rem  = RADIX_WIDTH'(work_q % VALUE_WIDTH'(RADIX));

    // Last digit: fixed count reached, or nothing significant left above this digit.
    assign is_last = FIXED_LENGTH ? (index_q == IDX_W'(NUM_DIGITS - 1))
                                  : (work_q < VALUE_WIDTH'(RADIX));

    // State, work and index registers; reset aborts any conversion in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            index_q <= index_d;
        end
    end

    // Next state: load on input accept, shift one digit out per handshake.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        index_d = index_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_EMIT;
                    work_d  = in_value;
                    index_d = '0;
                end
            end
            S_EMIT: begin
                if (digit_ready) begin
                    if (is_last) begin
                        state_d = S_IDLE;
                    end else begin
                        work_d  = quot;
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state; digit fields read zero when idle.
    always_comb begin
        in_ready    = 1'b0;
        digit_valid = 1'b0;
        digit       = '0;
        digit_index = '0;
        digit_last  = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_EMIT: begin
                digit_valid = 1'b1;
                digit       = rem;
                digit_index = index_q;
                digit_last  = is_last;
            end
            default: in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_smalldiv_digitizer.sv
// Bench for smalldiv_digitizer: a variable-length instance (u=0) and a
// fixed-length instance (u=1), driven by a vector table, hand sequences and
// random values checked against an arithmetic digit model.
module tb_smalldiv_digitizer;

    localparam int VW = 18;
    localparam int ND = 6;
    localparam int RW = 4;
    localparam int IW = 3;

    logic          clock = 1'b0;
    logic          resetn;
    logic          in_valid    [2];
    logic          in_ready    [2];
    logic [VW-1:0] in_value    [2];
    logic          digit_valid [2];
    logic          digit_ready [2];
    logic [RW-1:0] digit       [2];
    logic [IW-1:0] digit_index [2];
    logic          digit_last  [2];

    always #5 clock = ~clock;

    smalldiv_digitizer #(.RADIX(10), .VALUE_WIDTH(VW), .NUM_DIGITS(ND), .FIXED_LENGTH(1'b0)) u_var (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_value(in_value[0]),
        .digit_valid(digit_valid[0]), .digit_ready(digit_ready[0]), .digit(digit[0]),
        .digit_index(digit_index[0]), .digit_last(digit_last[0])
    );

    smalldiv_digitizer #(.RADIX(10), .VALUE_WIDTH(VW), .NUM_DIGITS(ND), .FIXED_LENGTH(1'b1)) u_fix (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_value(in_value[1]),
        .digit_valid(digit_valid[1]), .digit_ready(digit_ready[1]), .digit(digit[1]),
        .digit_index(digit_index[1]), .digit_last(digit_last[1])
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference: repeated /10 and %10; nibble i of bcd holds digit i.
    task automatic model(input logic [VW-1:0] v, input bit fl, output int n, output logic [23:0] bcd);
        int w;
        w   = int'(v);
        n   = 0;
        bcd = '0;
        do begin
            bcd[4*n +: 4] = 4'(w % 10);
            n++;
            w = w / 10;
        end while (fl ? (n < ND) : (w != 0));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one value to instance u and collect its digits.
    // mode 0: ready always 1; 1: ready pattern 1,0,0,...; 2: random ready.
    // In modes 1/2, in_valid/in_value are scrambled during emission to show they are ignored.
    task automatic convert(input int u, input logic [VW-1:0] v, input int mode,
                           output int n, output logic [23:0] bcd, output int cyc);
        int          budget;
        int          k;
        bit          done;
        bit          stalled;
        logic        dr;
        logic [RW-1:0] hd;
        logic [IW-1:0] hi;
        logic          hl;
        n = 0; bcd = '0; cyc = 0; k = 0; done = 0; stalled = 0;
        hd = '0; hi = '0; hl = 1'b0;
        budget = 0;
        while (!in_ready[u] && budget < 50) begin
            tick();
            budget++;
        end
        chk("in_ready_before_accept", 64'(in_ready[u]), 64'd1);
        in_valid[u] = 1'b1;
        in_value[u] = v;
        tick();
        cyc = 1;
        in_valid[u] = 1'b0;
        chk("first_digit_latency", 64'(digit_valid[u]), 64'd1);
        while (!done && cyc < 200) begin
            dr = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((k % 3) == 0) : 1'($urandom_range(0, 1));
            k++;
            digit_ready[u] = dr;
            chk("emit_valid", 64'(digit_valid[u]), 64'd1);
            chk("emit_in_ready", 64'(in_ready[u]), 64'd0);
            chk("emit_index", 64'(digit_index[u]), 64'(n));
            if (stalled) begin
                chk("stall_hold_digit", 64'(digit[u]), 64'(hd));
                chk("stall_hold_index", 64'(digit_index[u]), 64'(hi));
                chk("stall_hold_last", 64'(digit_last[u]), 64'(hl));
            end
            if (mode != 0 && !digit_last[u]) begin
                in_valid[u] = 1'($urandom_range(0, 1));
                in_value[u] = VW'($urandom);
            end else begin
                in_valid[u] = 1'b0;
            end
            hd = digit[u]; hi = digit_index[u]; hl = digit_last[u];
            if (dr) begin
                if (n < ND) bcd[4*n +: 4] = digit[u];
                n++;
                if (digit_last[u]) done = 1;
            end
            stalled = !dr;
            tick();
            cyc++;
        end
        if (!done) chk("emit_timeout", 64'd0, 64'd1);
        in_valid[u]    = 1'b0;
        digit_ready[u] = 1'b0;
        chk("after_last_in_ready", 64'(in_ready[u]), 64'd1);
        chk("after_last_valid", 64'(digit_valid[u]), 64'd0);
    endtask

    typedef struct {
        logic [VW-1:0] val;
        int            n;
        logic [23:0]   bcd;
    } vec_t;

    initial begin
        vec_t        tbl[12];
        int          n, cyc, en;
        logic [23:0] bcd, eb;
        logic [VW-1:0] v;

        // Expected digits written as BCD so the table reads as the decimal value.
        tbl[0]  = '{18'd0,      1, 24'h000000};
        tbl[1]  = '{18'd9,      1, 24'h000009};
        tbl[2]  = '{18'd10,     2, 24'h000010};
        tbl[3]  = '{18'd99,     2, 24'h000099};
        tbl[4]  = '{18'd100,    3, 24'h000100};
        tbl[5]  = '{18'd1234,   4, 24'h001234};
        tbl[6]  = '{18'd99999,  5, 24'h099999};
        tbl[7]  = '{18'd100000, 6, 24'h100000};
        tbl[8]  = '{18'd262143, 6, 24'h262143};
        tbl[9]  = '{18'd7,      1, 24'h000007};
        tbl[10] = '{18'd90,     2, 24'h000090};
        tbl[11] = '{18'd500,    3, 24'h000500};

        resetn = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0; in_value[u] = '0; digit_ready[u] = 1'b0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        tick();
        chk("reset_in_ready", 64'(in_ready[0]), 64'd1);
        chk("reset_digit_valid", 64'(digit_valid[0]), 64'd0);
        chk("reset_digit", 64'(digit[0]), 64'd0);
        chk("reset_digit_index", 64'(digit_index[0]), 64'd0);
        chk("reset_digit_last", 64'(digit_last[0]), 64'd0);

        // Zero: one digit 0, last, then idle on the next cycle.
        convert(0, 18'd0, 0, n, bcd, cyc);
        chk("zero_count", 64'(n), 64'd1);
        chk("zero_digit", 64'(bcd), 64'd0);
        chk("zero_cycles", 64'(cyc), 64'd2);

        // Max value at full rate: six digits, seven cycles.
        convert(0, 18'd262143, 0, n, bcd, cyc);
        chk("max_count", 64'(n), 64'd6);
        chk("max_digits", 64'(bcd), 64'h262143);
        chk("max_cycles", 64'(cyc), 64'd7);

        // 1234 with stalls.
        convert(0, 18'd1234, 1, n, bcd, cyc);
        chk("stall1234_count", 64'(n), 64'd4);
        chk("stall1234_digits", 64'(bcd), 64'h1234);

        // Vector table, rotating through ready modes.
        for (int i = 0; i < 12; i++) begin
            convert(0, tbl[i].val, i % 3, n, bcd, cyc);
            chk($sformatf("tbl%0d_count", i), 64'(n), 64'(tbl[i].n));
            chk($sformatf("tbl%0d_digits", i), 64'(bcd), 64'(tbl[i].bcd));
            if (i % 3 == 0) chk($sformatf("tbl%0d_cycles", i), 64'(cyc), 64'(tbl[i].n + 1));
        end

        // Fixed length: 42 -> 2,4,0,0,0,0 with last at index 5.
        convert(1, 18'd42, 0, n, bcd, cyc);
        chk("fixed42_count", 64'(n), 64'd6);
        chk("fixed42_digits", 64'(bcd), 64'h000042);
        convert(1, 18'd0, 2, n, bcd, cyc);
        chk("fixed0_count", 64'(n), 64'd6);
        chk("fixed0_digits", 64'(bcd), 64'h0);

        // Back-to-back 7 then 90 with in_valid held throughout.
        in_valid[0] = 1'b1; in_value[0] = 18'd7; digit_ready[0] = 1'b1;
        tick();
        chk("b2b_7_digit", 64'(digit[0]), 64'd7);
        chk("b2b_7_last", 64'(digit_last[0]), 64'd1);
        chk("b2b_7_in_ready", 64'(in_ready[0]), 64'd0);
        in_value[0] = 18'd90;
        tick();
        chk("b2b_gap_in_ready", 64'(in_ready[0]), 64'd1);
        chk("b2b_gap_valid", 64'(digit_valid[0]), 64'd0);
        tick();
        in_valid[0] = 1'b0;
        chk("b2b_90_d0", 64'(digit[0]), 64'd0);
        chk("b2b_90_i0", 64'(digit_index[0]), 64'd0);
        chk("b2b_90_l0", 64'(digit_last[0]), 64'd0);
        tick();
        chk("b2b_90_d1", 64'(digit[0]), 64'd9);
        chk("b2b_90_i1", 64'(digit_index[0]), 64'd1);
        chk("b2b_90_l1", 64'(digit_last[0]), 64'd1);
        tick();
        chk("b2b_end_in_ready", 64'(in_ready[0]), 64'd1);
        digit_ready[0] = 1'b0;

        // Reset during the third digit of 262143.
        in_valid[0] = 1'b1; in_value[0] = 18'd262143; digit_ready[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        chk("rst_third_digit", 64'(digit[0]), 64'd1);
        chk("rst_third_index", 64'(digit_index[0]), 64'd2);
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_valid", 64'(digit_valid[0]), 64'd0);
        chk("rst_async_in_ready", 64'(in_ready[0]), 64'd1);
        digit_ready[0] = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        tick();
        chk("rst_release_in_ready", 64'(in_ready[0]), 64'd1);
        chk("rst_release_valid", 64'(digit_valid[0]), 64'd0);
        convert(0, 18'd5, 0, n, bcd, cyc);
        chk("rst_next_count", 64'(n), 64'd1);
        chk("rst_next_digit", 64'(bcd), 64'd5);

        // Random values against the model, both instances.
        for (int i = 0; i < 40; i++) begin
            v = (i % 4 == 0) ? VW'($urandom_range(0, 120)) : VW'($urandom_range(0, 262143));
            model(v, 1'b0, en, eb);
            convert(0, v, int'($urandom_range(0, 2)), n, bcd, cyc);
            chk($sformatf("rand%0d_v%0d_count", i, v), 64'(n), 64'(en));
            chk($sformatf("rand%0d_v%0d_digits", i, v), 64'(bcd), 64'(eb));
        end
        for (int i = 0; i < 8; i++) begin
            v = VW'($urandom_range(0, 262143));
            model(v, 1'b1, en, eb);
            convert(1, v, int'($urandom_range(0, 2)), n, bcd, cyc);
            chk($sformatf("frand%0d_v%0d_count", i, v), 64'(n), 64'(en));
            chk($sformatf("frand%0d_v%0d_digits", i, v), 64'(bcd), 64'(eb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
